mac_vec: RTL and testbench
==========================

Name: mac_vec

Overview:
- Parametrised, handshaked successor to the scalar MAC.
- Computes a signed dot product of a programmable number of (a, b) beats into a wide accumulator.
- Requantises the accumulated result to OUT_W bits and presents it on a valid/ready output port.
- Sits between the weight/activation streamers and the neuron activation stage.

Parameters:
- DATA_W, 8, width of signed operands a and b
- ACC_W, 24, width of the signed internal accumulator; must be >= 2*DATA_W
- OUT_W, 8, width of the signed result
- SHIFT, 0, arithmetic right shift applied to the accumulator before narrowing; 0 <= SHIFT < ACC_W
- LEN_W, 8, width of the vector-length field

Ports:
- clk  in  1  clock; all logic on rising edge
- reset  in  1  asynchronous, active-high reset
- start  in  1  begin a new dot product; honoured only in IDLE
- len  in  LEN_W  number of beats, unsigned; sampled on accepted start
- clear  in  1  synchronous abort back to IDLE
- in_valid  in  1  a/b beat valid
- in_ready  out  1  block accepts a beat
- a  in  DATA_W  signed operand
- b  in  DATA_W  signed operand
- out_valid  out  1  result valid
- out_ready  in  1  consumer accepts result
- out  out  OUT_W  signed requantised result
- busy  out  1  state != IDLE

Behaviour:
- Reset (asynchronous, active-high) forces state = IDLE, acc = 0, count = 0, out = 0, out_valid = 0, in_ready = 0, busy = 0.
- States: IDLE, ACCUM, OUTPUT.
- IDLE:
  - start = 1 latches len and clears acc and count.
  - len != 0: go to ACCUM.
  - len == 0: go directly to OUTPUT with result 0.
- ACCUM:
  - in_ready = 1 (registered, asserted from the cycle after entry).
  - On in_valid && in_ready: acc <= acc + sign-extended(a*b), count++.
  - Product is a full 2*DATA_W signed value.
  - The accumulator wraps modulo 2^ACC_W; no internal saturation.
  - When the accepted beat is the len-th beat, the next state is OUTPUT and in_ready drops the next cycle.
  - in_valid while in_ready = 0 is ignored; no beat is consumed.
- OUTPUT:
  - out_valid = 1 the cycle after the last beat is accepted (1-cycle latency).
  - out = narrow(final acc >>> SHIFT), registered. The value includes the final beat.
  - out and out_valid hold stable until out_ready = 1.
  - On the handshake cycle, go to IDLE; out_valid = 0 next cycle. out keeps its last value.
- start outside IDLE is ignored.
- start asserted on the same cycle as the output handshake is ignored. A new start needs a cycle in IDLE.
- clear = 1 in any state: next cycle state = IDLE, acc = 0, count = 0, out_valid = 0, in_ready = 0.
  - clear has priority over start and over a simultaneous beat or handshake.
  - out retains its last value.
- Asynchronous reset asserted mid-operation discards the partial sum. No output is produced for the aborted vector.
- narrow() is set by MAC_SAT_EN (see Optional Feature).

Optional Feature:
- Macro: MAC_SAT_EN.
- Defined: narrow() saturates the shifted accumulator to [-2^(OUT_W-1), 2^(OUT_W-1)-1]. For OUT_W=8 the range is -128..127.
- Undefined: narrow() keeps the low OUT_W bits (two's-complement wrap).
- Saturation applies only at the output; the internal accumulator always wraps.

Test Plan:
- Defaults, len=4, beats (1,5),(4,10),(12,2),(2,3) with in_valid held high:
  - in_ready low after the 4th beat.
  - out_valid 1 cycle later with out = 75.
  - busy falls after out_ready handshake.
- len=5, beats (1,-1),(-1,1),(-1,-2),(-20,2),(-7,-2), in_valid toggled every other cycle: out = -26; only valid beats are counted.
- len=4, four beats of (100,100), acc = 40000:
  - out = 127 with MAC_SAT_EN.
  - out = 64 without MAC_SAT_EN.
  - SHIFT=8 build without MAC_SAT_EN: out = 156 mod 256, i.e. -100 as signed 8-bit.
- Backpressure: after the 75 result, out_ready low for 5 cycles:
  - out_valid and out = 75 stable throughout.
  - start pulses during the hold are ignored.
  - Handshake returns to IDLE.
- len=0 start: OUTPUT next cycle with out = 0; no beats are consumed.
- Abort cases:
  - clear after 2 of 4 beats gives IDLE and acc = 0 the next cycle.
  - reset pulse mid-vector gives all outputs 0 immediately.
  - A following len=1 beat (3,-4) yields out = -12.

Source files
------------

// File: rtl/mac_vec.sv
// -----------------------------------------------------------------------------
// mac_vec -- handshaked vector multiply-accumulate (signed dot product)
//
// Accepts a programmable number of signed (a, b) beats, accumulates the full
// 2*DATA_W products into a wrapping ACC_W accumulator, then requantises the
// sum (arithmetic shift right by SHIFT, then narrow to OUT_W bits) and offers
// it on a valid/ready result port. Sits between the weight/activation
// streamers and the neuron activation stage.
//
// Optional feature macro: MAC_SAT_EN
//   defined   : narrowing saturates to [-2^(OUT_W-1), 2^(OUT_W-1)-1]
//   undefined : narrowing keeps the low OUT_W bits (two's-complement wrap)
//   The internal accumulator always wraps, whichever way the macro is set.
//
// Ports
//   clk          in   1      clock, rising edge
//   reset        in   1      asynchronous active-high reset
//   start        in   1      begin a new dot product (honoured only in IDLE)
//   len          in   LEN_W  number of beats, unsigned, sampled on start
//   clear        in   1      synchronous abort back to IDLE (top priority)
//   in_valid     in   1      a/b beat valid
//   in_ready     out  1      block accepts a beat (registered)
//   a, b         in   DATA_W signed operands
//   out_valid    out  1      result valid (registered)
//   out_ready    in   1      consumer accepts result
//   out          out  OUT_W  signed requantised result (registered)
//   busy         out  1      state != IDLE (registered)
//   o_dbg_state  out  2      FSM state: 0 IDLE, 1 ACCUM, 2 OUTPUT
//   o_dbg_acc    out  ACC_W  accumulator contents
//   o_dbg_count  out  LEN_W  beats accepted so far in this vector
//
// Handshake semantics (both ports): a transfer happens on a rising clock edge
// where valid and ready are both 1. A producer holding valid keeps its data
// stable until that edge; ready may be asserted independently of valid, and
// valid never depends combinationally on ready.
// -----------------------------------------------------------------------------
module mac_vec #(
  parameter int DATA_W = 8,
  parameter int ACC_W  = 24,
  parameter int OUT_W  = 8,
  parameter int SHIFT  = 0,
  parameter int LEN_W  = 8
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     start,
  input  logic [LEN_W-1:0]         len,
  input  logic                     clear,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic signed [DATA_W-1:0] a,
  input  logic signed [DATA_W-1:0] b,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic signed [OUT_W-1:0]  out,
  output logic                     busy,
  output logic [1:0]               o_dbg_state,
  output logic [ACC_W-1:0]         o_dbg_acc,
  output logic [LEN_W-1:0]         o_dbg_count
);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCUM  = 2'd1,
    ST_OUTPUT = 2'd2
  } state_t;

  // ---------------------------------------------------------------------------
  // State registers
  // ---------------------------------------------------------------------------
  state_t                    r_state;
  logic [LEN_W-1:0]          r_len;
  logic [LEN_W-1:0]          r_count;
  logic signed [ACC_W-1:0]   r_acc;
  logic [OUT_W-1:0]          r_out;
  logic                      r_out_valid;
  logic                      r_in_ready;
  logic                      r_busy;

  // ---------------------------------------------------------------------------
  // Datapath
  // ---------------------------------------------------------------------------
  logic signed [2*DATA_W-1:0] w_prod;
  logic signed [ACC_W-1:0]    w_prod_ext;
  logic signed [ACC_W-1:0]    w_acc_next;
  logic signed [ACC_W-1:0]    w_shifted;
  logic [OUT_W-1:0]           w_narrow;
  logic                       w_beat;
  logic                       w_last;

  // Both operands are signed, so the product is the exact signed value.
  assign w_prod     = a * b;
  // Assigning a signed value to a wider signed net sign-extends it.
  assign w_prod_ext = w_prod;
  // Modulo-2^ACC_W wrap comes for free from the fixed accumulator width.
  assign w_acc_next = r_acc + w_prod_ext;
  assign w_shifted  = w_acc_next >>> SHIFT;

  // r_in_ready is only ever set while in ACCUM, so it qualifies the beat alone.
  assign w_beat = in_valid & r_in_ready;
  assign w_last = ((r_count + LEN_W'(1)) == r_len);

`ifdef MAC_SAT_EN
  // The shifted sum fits in OUT_W bits exactly when every bit from the OUT_W
  // sign position upward agrees; otherwise clamp toward the sign of the sum.
  logic [ACC_W-OUT_W:0] w_top;
  logic                 w_fits;

  assign w_top  = w_shifted[ACC_W-1:OUT_W-1];
  assign w_fits = (&w_top) | ~(|w_top);

  always_comb begin
    w_narrow = w_shifted[OUT_W-1:0];
    if (!w_fits) begin
      if (w_shifted[ACC_W-1]) begin
        w_narrow = {1'b1, {(OUT_W-1){1'b0}}};
      end else begin
        w_narrow = {1'b0, {(OUT_W-1){1'b1}}};
      end
    end
  end
`else
  // Plain two's-complement wrap: keep the low OUT_W bits of the shifted sum.
  assign w_narrow = OUT_W'(w_shifted);
`endif

  // ---------------------------------------------------------------------------
  // Control FSM, all outputs registered
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state     <= ST_IDLE;
      r_len       <= '0;
      r_count     <= '0;
      r_acc       <= '0;
      r_out       <= '0;
      r_out_valid <= 1'b0;
      r_in_ready  <= 1'b0;
      r_busy      <= 1'b0;
    end else if (clear) begin
      // Abort wins over start, a beat or a result handshake in the same cycle.
      // The last result stays visible on out.
      r_state     <= ST_IDLE;
      r_count     <= '0;
      r_acc       <= '0;
      r_out_valid <= 1'b0;
      r_in_ready  <= 1'b0;
      r_busy      <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (start) begin
            r_len   <= len;
            r_count <= '0;
            r_acc   <= '0;
            r_busy  <= 1'b1;
            if (len == '0) begin
              // Empty vector: the dot product is zero, present it at once.
              r_state     <= ST_OUTPUT;
              r_out       <= '0;
              r_out_valid <= 1'b1;
            end else begin
              r_state    <= ST_ACCUM;
              r_in_ready <= 1'b1;
            end
          end
        end

        ST_ACCUM: begin
          if (w_beat) begin
            r_acc   <= w_acc_next;
            r_count <= r_count + LEN_W'(1);
            if (w_last) begin
              // Requantise from the sum that already includes this beat so
              // the result appears one cycle after the final beat.
              r_state     <= ST_OUTPUT;
              r_in_ready  <= 1'b0;
              r_out       <= w_narrow;
              r_out_valid <= 1'b1;
            end
          end
        end

        ST_OUTPUT: begin
          // Result held stable until taken; start is ignored here, so a new
          // vector always needs at least one cycle back in IDLE.
          if (out_ready) begin
            r_state     <= ST_IDLE;
            r_out_valid <= 1'b0;
            r_busy      <= 1'b0;
          end
        end

        default: begin
          r_state     <= ST_IDLE;
          r_out_valid <= 1'b0;
          r_in_ready  <= 1'b0;
          r_busy      <= 1'b0;
        end
      endcase
    end
  end

  // ---------------------------------------------------------------------------
  // Outputs
  // ---------------------------------------------------------------------------
  assign in_ready    = r_in_ready;
  assign out_valid   = r_out_valid;
  assign out         = r_out;
  assign busy        = r_busy;
  assign o_dbg_state = r_state;
  assign o_dbg_acc   = r_acc;
  assign o_dbg_count = r_count;

endmodule

// File: tb/tb_mac_vec.sv
// -----------------------------------------------------------------------------
// tb_mac_vec -- directed self-checking bench for mac_vec.
// Two instances share all inputs: u_dut with default parameters and u_dut8
// with SHIFT=8, so both requantisation paths are observed on every vector.
// -----------------------------------------------------------------------------
module tb_mac_vec;

  localparam int DATA_W = 8;
  localparam int ACC_W  = 24;
  localparam int OUT_W  = 8;
  localparam int LEN_W  = 8;

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_ACCUM  = 2'd1;
  localparam logic [1:0] S_OUTPUT = 2'd2;

  // Four beats of (100,100) give 40000 = 0x9C40.
`ifdef MAC_SAT_EN
  localparam int EXP_BIG  = 127;
  localparam int EXP_BIG8 = 127;
`else
  localparam int EXP_BIG  = 64;
  localparam int EXP_BIG8 = -100;
`endif

  // ---------------------------------------------------------------------------
  // Clock / reset / DUT
  // ---------------------------------------------------------------------------
  logic                     clk = 1'b0;
  logic                     reset;
  logic                     start;
  logic [LEN_W-1:0]         len;
  logic                     clear;
  logic                     in_valid;
  logic signed [DATA_W-1:0] a;
  logic signed [DATA_W-1:0] b;
  logic                     out_ready;

  logic                     in_ready_0, out_valid_0, busy_0;
  logic signed [OUT_W-1:0]  out_0;
  logic [1:0]               state_0;
  logic [ACC_W-1:0]         acc_0;
  logic [LEN_W-1:0]         count_0;

  logic                     in_ready_8, out_valid_8, busy_8;
  logic signed [OUT_W-1:0]  out_8;
  logic [1:0]               state_8;
  logic [ACC_W-1:0]         acc_8;
  logic [LEN_W-1:0]         count_8;

  always #5 clk = ~clk;

  mac_vec u_dut (
    .clk(clk), .reset(reset), .start(start), .len(len), .clear(clear),
    .in_valid(in_valid), .in_ready(in_ready_0), .a(a), .b(b),
    .out_valid(out_valid_0), .out_ready(out_ready), .out(out_0), .busy(busy_0),
    .o_dbg_state(state_0), .o_dbg_acc(acc_0), .o_dbg_count(count_0)
  );

  mac_vec #(.SHIFT(8)) u_dut8 (
    .clk(clk), .reset(reset), .start(start), .len(len), .clear(clear),
    .in_valid(in_valid), .in_ready(in_ready_8), .a(a), .b(b),
    .out_valid(out_valid_8), .out_ready(out_ready), .out(out_8), .busy(busy_8),
    .o_dbg_state(state_8), .o_dbg_acc(acc_8), .o_dbg_count(count_8)
  );

  // ---------------------------------------------------------------------------
  // Checking
  // ---------------------------------------------------------------------------
  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0d (0x%0h), expected %0d (0x%0h)",
                tag, $signed(obs), obs, $signed(exp), exp);
  endtask

  // ---------------------------------------------------------------------------
  // Driver tasks: inputs change 1 time unit after the rising edge, outputs are
  // sampled at the same point, well away from the next active edge.
  // ---------------------------------------------------------------------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_start(input logic [LEN_W-1:0] l);
    start = 1'b1;
    len   = l;
    tick();
    start = 1'b0;
  endtask

  task automatic send_beat(input logic signed [DATA_W-1:0] va,
                           input logic signed [DATA_W-1:0] vb);
    int waited;
    a        = va;
    b        = vb;
    in_valid = 1'b1;
    waited   = 0;
    while (!in_ready_0 && waited < 20) begin
      tick();
      waited++;
    end
    if (!in_ready_0) check("beat_wait_in_ready", in_ready_0, 1'b1);
    tick();
    in_valid = 1'b0;
  endtask

  task automatic handshake();
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
  endtask

  // ---------------------------------------------------------------------------
  // Directed sequence
  // ---------------------------------------------------------------------------
  logic signed [DATA_W-1:0] t2_a [5];
  logic signed [DATA_W-1:0] t2_b [5];

  initial begin
    reset = 1'b1; start = 1'b0; len = '0; clear = 1'b0;
    in_valid = 1'b0; a = '0; b = '0; out_ready = 1'b0;
    t2_a = '{8'sd1, -8'sd1, -8'sd1, -8'sd20, -8'sd7};
    t2_b = '{-8'sd1, 8'sd1, -8'sd2, 8'sd2, -8'sd2};

    // Reset state
    tick(); tick();
    check("rst_out_valid", out_valid_0, 1'b0);
    check("rst_in_ready",  in_ready_0,  1'b0);
    check("rst_busy",      busy_0,      1'b0);
    check("rst_out",       out_0,       0);
    check("rst_state",     state_0,     S_IDLE);
    check("rst_acc",       acc_0,       0);
    check("rst_count",     count_0,     0);
    reset = 1'b0;
    tick();

    // len=4 with in_valid held high: 5 + 40 + 24 + 6 = 75
    do_start(8'd4);
    check("t1_state_accum", state_0,    S_ACCUM);
    check("t1_in_ready",    in_ready_0, 1'b1);
    check("t1_busy",        busy_0,     1'b1);
    send_beat(8'sd1, 8'sd5);
    send_beat(8'sd4, 8'sd10);
    send_beat(8'sd12, 8'sd2);
    send_beat(8'sd2, 8'sd3);
    check("t1_in_ready_low", in_ready_0,  1'b0);
    check("t1_out_valid",    out_valid_0, 1'b1);
    check("t1_out",          out_0,       75);
    check("t1_state_output", state_0,     S_OUTPUT);
    check("t1_out_shift8",   out_8,       0);

    // Backpressure: hold for 5 cycles while start pulses are ignored
    for (int i = 0; i < 5; i++) begin
      start = (i % 2 == 0);
      len   = 8'd2;
      tick();
      check("bp_out_valid", out_valid_0, 1'b1);
      check("bp_out",       out_0,       75);
      check("bp_state",     state_0,     S_OUTPUT);
    end
    // start on the handshake cycle must not launch a new vector
    start = 1'b1; len = 8'd3;
    handshake();
    start = 1'b0;
    check("hs_state",     state_0,     S_IDLE);
    check("hs_busy",      busy_0,      1'b0);
    check("hs_out_valid", out_valid_0, 1'b0);
    check("hs_out_kept",  out_0,       75);
    tick();
    check("hs_still_idle", state_0, S_IDLE);

    // len=5, in_valid toggled: -1 -1 +2 -40 +14 = -26
    do_start(8'd5);
    for (int i = 0; i < 5; i++) begin
      send_beat(t2_a[i], t2_b[i]);
      if (i < 4) begin
        a = 8'sd50; b = 8'sd50; in_valid = 1'b0;
        tick();
        if (i == 1) check("t2_count_gap", count_0, 2);
      end
    end
    check("t2_out_valid", out_valid_0, 1'b1);
    check("t2_out",       out_0,       -26);
    check("t2_out_shift8", out_8,      -1);
    handshake();

    // len=0: result 0 next cycle, stray beat not consumed
    start = 1'b1; len = 8'd0;
    in_valid = 1'b1; a = 8'sd7; b = 8'sd7;
    tick();
    start = 1'b0;
    check("l0_state",     state_0,     S_OUTPUT);
    check("l0_out_valid", out_valid_0, 1'b1);
    check("l0_out",       out_0,       0);
    check("l0_in_ready",  in_ready_0,  1'b0);
    check("l0_count",     count_0,     0);
    in_valid = 1'b0;
    handshake();

    // Four beats of (100,100): acc = 40000, narrowing path exercised
    do_start(8'd4);
    for (int i = 0; i < 4; i++) send_beat(8'sd100, 8'sd100);
    check("big_acc",       acc_0,       40000);
    check("big_out_valid", out_valid_0, 1'b1);
    check("big_out",       out_0,       EXP_BIG);
    check("big_out_shift8", out_8,      EXP_BIG8);
    handshake();

    // clear after 2 of 4 beats, with a simultaneous beat offered
    do_start(8'd4);
    send_beat(8'sd3, 8'sd3);
    send_beat(8'sd2, 8'sd2);
    check("clr_acc_before", acc_0,   13);
    check("clr_count_before", count_0, 2);
    clear = 1'b1; in_valid = 1'b1; a = 8'sd9; b = 8'sd9;
    tick();
    clear = 1'b0; in_valid = 1'b0;
    check("clr_state",     state_0,     S_IDLE);
    check("clr_acc",       acc_0,       0);
    check("clr_count",     count_0,     0);
    check("clr_in_ready",  in_ready_0,  1'b0);
    check("clr_busy",      busy_0,      1'b0);
    check("clr_out_valid", out_valid_0, 1'b0);
    check("clr_out_kept",  out_0,       EXP_BIG);

    // Asynchronous reset mid-vector, then a len=1 vector (3,-4) = -12
    do_start(8'd3);
    send_beat(8'sd5, 8'sd5);
    check("ar_acc_before", acc_0, 25);
    #2 reset = 1'b1;
    #1;
    check("ar_out",       out_0,       0);
    check("ar_out_valid", out_valid_0, 1'b0);
    check("ar_in_ready",  in_ready_0,  1'b0);
    check("ar_busy",      busy_0,      1'b0);
    check("ar_state",     state_0,     S_IDLE);
    check("ar_acc",       acc_0,       0);
    reset = 1'b0;
    tick();
    do_start(8'd1);
    send_beat(8'sd3, -8'sd4);
    check("post_out_valid",  out_valid_0, 1'b1);
    check("post_out",        out_0,       -12);
    check("post_out_shift8", out_8,       -1);
    handshake();
    check("post_busy", busy_0, 1'b0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
